// File: rtl/mux_pipe_nto1_if.sv
// rtl/mux_pipe_nto1_if.sv - handshake/data bundle for the pipelined N-to-1 mux
//
// Signals (direction as seen by the mux, i.e. the slave modport):
//   data_i   in   num*size  packed channels, channel k at [k*size +: size]
//   select_i in   selw      channel index, sampled on accept only
//   valid_i  in   1         upstream transfer request
//   ready_o  out  1         mux can accept this cycle (registered)
//   data_o   out  size      registered selected word
//   valid_o  out  1         data_o holds an unconsumed word
//   ready_i  in   1         downstream takes data_o this cycle
//   err_o    out  1         sticky out-of-range select flag
interface mux_pipe_nto1_if #(
    parameter int size = 32,
    parameter int num  = 4,
    parameter int selw = 2
);
    logic [num*size-1:0] data_i;
    logic [selw-1:0]     select_i;
    logic                valid_i;
    logic                ready_o;
    logic [size-1:0]     data_o;
    logic                valid_o;
    logic                ready_i;
    logic                err_o;

    modport master (
        output data_i, select_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, err_o
    );

    modport slave (
        input  data_i, select_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, err_o
    );
endinterface

// File: rtl/mux_pipe_nto1.sv
// rtl/mux_pipe_nto1.sv - pipelined N-to-1 mux with two-entry skid buffer
//
// Selects one of num packed channels on each accepted transfer and delivers
// it one cycle later through an output register backed by a skid register,
// so ready_o is purely registered and throughput is one word per cycle.
//
// Ports:
//   clk_i  in   rising-edge clock
//   rst_i  in   asynchronous active-high reset
//   bus    slave modport of mux_pipe_nto1_if (data/select/valid in,
//          ready/data/valid out, ready in, err out)
//
// Optional feature: define MUX_PIPE_SELCHK_EN to build the sticky
// out-of-range select detector driving err_o; otherwise err_o is tied 0.
module mux_pipe_nto1 #(
    parameter int size = 32,
    parameter int num  = 4,
    parameter int selw = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mux_pipe_nto1_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] out_data_q, out_data_d;
    logic [size-1:0] skid_data_q, skid_data_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;
    logic [size-1:0] sel_word;
    logic            accept;
    logic            consume;

    assign accept  = bus.valid_i & ready_q;
    assign consume = valid_q & bus.ready_i;

    // Out-of-range selects yield zero; the loop bound keeps every slice legal.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < num; k++) begin
            if (int'(bus.select_i) == k) begin
                sel_word = bus.data_i[k*size +: size];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !consume)      state_d = ST_TWO;
                else if (!accept && consume) state_d = ST_EMPTY;
            end
            ST_TWO:   if (consume) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath loads plus the registered flags; valid/ready are computed from
    // the next state so both leave the block straight from flops.
    always_comb begin
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_EMPTY: if (accept) out_data_d = sel_word;
            ST_ONE: begin
                if (accept && consume)  out_data_d  = sel_word;
                else if (accept)        skid_data_d = sel_word;
            end
            ST_TWO:   if (consume) out_data_d = skid_data_q;
            default: ;
        endcase
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    assign bus.data_o  = out_data_q;
    assign bus.valid_o = valid_q;
    assign bus.ready_o = ready_q;

`ifdef MUX_PIPE_SELCHK_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept && (int'(bus.select_i) >= num)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// tb/tb_mux_pipe_nto1.sv - self-checking bench for mux_pipe_nto1
module tb_mux_pipe_nto1;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mux_pipe_nto1_if #(.size(32), .num(4), .selw(2)) bus  ();
    mux_pipe_nto1_if #(.size(32), .num(3), .selw(2)) bus3 ();

    mux_pipe_nto1 #(.size(32), .num(4), .selw(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    mux_pipe_nto1 #(.size(32), .num(3), .selw(2)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX_PIPE_SELCHK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    // Reference: a FIFO of accepted words with capacity two. Head is what
    // data_o shows; ready means fewer than two words are held.
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd_channels();
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic cyc(input bit v, input logic [1:0] s, input logic [127:0] dat, input bit r);
        logic [31:0] w;
        bit acc;
        bit con;
        bus.data_i   = dat;
        bus.select_i = s;
        bus.valid_i  = v;
        bus.ready_i  = r;
        w   = dat[int'(s)*32 +: 32];
        acc = v && (q.size() < 2);
        con = (q.size() > 0) && r;
        @(posedge clk);
        #1;
        if (con) void'(q.pop_front());
        if (acc) q.push_back(w);
        chk("ready_o", {63'd0, bus.ready_o}, {63'd0, q.size() < 2});
        chk("valid_o", {63'd0, bus.valid_o}, {63'd0, q.size() > 0});
        if (q.size() > 0) chk("data_o", {32'd0, bus.data_o}, {32'd0, q[0]});
        chk("err_o", {63'd0, bus.err_o}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.valid_i  = 1'b1;
        bus3.valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        q.delete();
    endtask

    initial begin
        logic [127:0] d;
        logic [95:0]  d3;

        rst = 1'b1;
        bus.data_i = '0;  bus.select_i = '0;  bus.valid_i = 1'b0;  bus.ready_i = 1'b0;
        bus3.data_i = '0; bus3.select_i = '0; bus3.valid_i = 1'b0; bus3.ready_i = 1'b0;
        #1;
        chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);
        chk("rst_data",  {32'd0, bus.data_o},  64'd0);
        chk("rst_err",   {63'd0, bus3.err_o},  64'd0);
        do_reset();

        // Single accept of channel 2, then drain.
        d = rnd_channels();
        d[64 +: 32] = 32'hDEADBEEF;
        cyc(1'b1, 2'd2, d, 1'b1);
        chk("single_data", {32'd0, bus.data_o}, 64'h0000_0000_DEAD_BEEF);
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);
        chk("single_drain", {63'd0, bus.valid_o}, 64'd0);

        // Back-to-back stream of selects 0..3.
        for (int i = 0; i < 4; i++) begin
            d = rnd_channels();
            cyc(1'b1, 2'(i), d, 1'b1);
            chk("stream_data", {32'd0, bus.data_o}, {32'd0, d[i*32 +: 32]});
            chk("stream_ready", {63'd0, bus.ready_o}, 64'd1);
        end
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);

        // Fill both entries with ready_i low, then drain in order.
        cyc(1'b1, 2'd1, rnd_channels(), 1'b0);
        cyc(1'b1, 2'd3, rnd_channels(), 1'b0);
        chk("full_ready", {63'd0, bus.ready_o}, 64'd0);
        cyc(1'b1, 2'd0, rnd_channels(), 1'b0);
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);
        chk("drain_ready", {63'd0, bus.ready_o}, 64'd1);
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);

        // Randomised traffic against the FIFO reference.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), rnd_channels(),
                1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset while both entries are full.
        cyc(1'b1, 2'd2, rnd_channels(), 1'b0);
        cyc(1'b1, 2'd1, rnd_channels(), 1'b0);
        cyc(1'b0, 2'd0, rnd_channels(), 1'b0);
        #2;
        rst = 1'b1;
        bus.valid_i = 1'b1;
        #1;
        chk("arst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("arst_ready", {63'd0, bus.ready_o}, 64'd1);
        chk("arst_data",  {32'd0, bus.data_o},  64'd0);
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_no_accept", {63'd0, bus.valid_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);
        chk("no_stale", {63'd0, bus.valid_o}, 64'd0);
        cyc(1'b1, 2'd3, rnd_channels(), 1'b1);
        cyc(1'b0, 2'd0, rnd_channels(), 1'b1);

        // Three-channel instance: select 3 is out of range.
        @(negedge clk);
        d3 = {32'($urandom), 32'($urandom), 32'($urandom)};
        bus3.data_i = d3; bus3.select_i = 2'd3; bus3.valid_i = 1'b1; bus3.ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("oor_data",  {32'd0, bus3.data_o},  64'd0);
        chk("oor_valid", {63'd0, bus3.valid_o}, 64'd1);
        chk("oor_err",   {63'd0, bus3.err_o},   {63'd0, ERR_ON});
        bus3.select_i = 2'd1;
        @(posedge clk);
        #1;
        chk("inr_data", {32'd0, bus3.data_o}, {32'd0, d3[32 +: 32]});
        chk("err_sticky", {63'd0, bus3.err_o}, {63'd0, ERR_ON});
        bus3.valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("err_hold", {63'd0, bus3.err_o}, {63'd0, ERR_ON});
        chk("oor_drain", {63'd0, bus3.valid_o}, 64'd0);
        do_reset();
        #1;
        chk("err_cleared", {63'd0, bus3.err_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nto1.md
MUX_PIPE_NTO1 -- requirements
Module: mux_pipe_nto1

Interface
REQ-001 Parameter: size, 32, data width of every channel and of data_o (1..64).
REQ-002 Parameter: num, 4, number of input channels (2..8).
REQ-003 Parameter: selw, 2, select width; SHALL satisfy 2**selw >= num.
REQ-004 clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 data_i  input  num*size  packed channels; channel k occupies bits [k*size +: size].
REQ-007 select_i  input  selw  channel index, sampled only on an accepted transfer.
REQ-008 valid_i  input  1  upstream transfer request.
REQ-009 ready_o  output  1  block can accept a transfer this cycle.
REQ-010 data_o  output  size  registered selected data.
REQ-011 valid_o  output  1  data_o holds an unconsumed result.
REQ-012 ready_i  input  1  downstream accepts data_o this cycle.
REQ-013 err_o  output  1  sticky out-of-range-select flag (see Configuration).

Function
REQ-014 Accept SHALL occur when valid_i and ready_o are both 1 at a rising edge; consume SHALL occur when valid_o and ready_i are both 1.
REQ-015 The selected word SHALL be data_i channel select_i when select_i < num, else all-zero.
REQ-016 Storage SHALL be two entries: output register (OUT) driving data_o/valid_o, and skid register (SKID).
REQ-017 States: EMPTY (OUT and SKID empty), ONE (OUT full, SKID empty), TWO (both full).
REQ-018 EMPTY: accept -> ONE, OUT loads the selected word.
REQ-019 ONE: accept with consume -> ONE, OUT reloads; accept without consume -> TWO, SKID loads; consume without accept -> EMPTY; neither -> hold.
REQ-020 TWO: consume -> ONE, OUT loads SKID; no consume -> hold; accept is impossible because ready_o is 0.
REQ-021 ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO, and SHALL be driven from a register only (no combinational path from ready_i).
REQ-022 Latency SHALL be one cycle: a word accepted at edge N appears on data_o with valid_o=1 after edge N.
REQ-023 Sustained throughput SHALL be one word per cycle while ready_i is 1.
REQ-024 Words SHALL leave in acceptance order; no word SHALL be dropped or duplicated.
REQ-025 data_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-026 select_i and data_i SHALL be ignored in cycles without accept.

Reset
REQ-027 On rst_i=1, immediately and regardless of clock: state EMPTY, valid_o=0, ready_o=1, data_o=0, SKID data=0, err_o=0.
REQ-028 Reset asserted mid-transfer SHALL discard both stored words; the first accept after release SHALL behave as from EMPTY.
REQ-029 Deassertion SHALL take effect at the first rising edge after rst_i falls; no accept SHALL occur while rst_i=1.

Configuration
REQ-030 Macro MUX_PIPE_SELCHK_EN: when defined, err_o SHALL set to 1 on any accept with select_i >= num and stay 1 until reset.
REQ-031 Without MUX_PIPE_SELCHK_EN, err_o SHALL be constant 0 and no check logic SHALL be built; data behaviour (REQ-015) is unchanged.

Verification
REQ-032 Reset, then a single accept with select_i=2 and channel 2=32'hDEADBEEF, ready_i=1 -> next cycle data_o=32'hDEADBEEF, valid_o=1; following cycle valid_o=0.
REQ-033 Stream of selects 0,1,2,3 on consecutive cycles with ready_i=1 -> data_o shows channels 0,1,2,3 on four consecutive cycles; ready_o stays 1.
REQ-034 ready_i=0, two accepts (A then B) -> ready_o=0 after the second; data_o=A held; raise ready_i -> A then B on consecutive cycles, ready_o returns to 1.
REQ-035 num=3, accept with select_i=3 -> data_o=0; with MUX_PIPE_SELCHK_EN err_o=1 persists until rst_i; without it err_o stays 0.
REQ-036 State TWO, assert rst_i between clock edges -> valid_o=0, ready_o=1, data_o=0 immediately; no stale word appears after release.
